pixel_writer: RTL and testbench

- Consumer end of the pixel stream that clear_unit and later raster units produce (`pixel_valid`/`pixel_x`/`pixel_y`/`pixel_color`).
- Clips each pixel against the framebuffer bounds and computes its byte address.
- Buffers in-bounds pixels in a FIFO and issues 32-bit memory write requests over a valid/ready handshake toward the framebuffer memory port.
- Reports drops, overflow and idle status for the command/status registers.

---
 rtl/pixel_writer.sv | 127 ++++++++++++
 tb/tb_pixel_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// Pixel stream sink: clips pixels to the framebuffer and computes byte addresses.
// In-bounds pixels are buffered in a FIFO and drained as 32-bit write requests.
module pixel_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fb_base,
  input  logic [31:0]      fb_width,
  input  logic [31:0]      fb_height,
  input  logic             pixel_valid,
  input  logic [31:0]      pixel_x,
  input  logic [31:0]      pixel_y,
  input  logic [31:0]      pixel_color,
  output logic             pixel_ready,
  output logic             mem_wr_valid,
  input  logic             mem_wr_ready,
  output logic [31:0]      mem_wr_addr,
  output logic [31:0]      mem_wr_data,
  input  logic             clear_flags,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  output logic             idle
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0]      addr_mem_q [FIFO_DEPTH];
  logic [31:0]      data_mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             full_s, empty_s, in_bounds_s;
  logic             accept_s, push_s, drop_s, pop_s;
  logic [31:0]      lin_idx_s, pix_addr_s;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_s = (wr_ptr_q == rd_ptr_q);

  assign in_bounds_s = (pixel_x < fb_width) && (pixel_y < fb_height);
  assign accept_s    = pixel_valid && !full_s;
  assign push_s      = accept_s && in_bounds_s;
  assign drop_s      = accept_s && !in_bounds_s;
  assign pop_s       = !empty_s && mem_wr_ready;

  // Row-major address, truncated to 32 bits so it wraps silently.
  assign lin_idx_s  = (pixel_y * fb_width) + pixel_x;
  assign pix_addr_s = fb_base + {lin_idx_s[29:0], 2'b00};

  // Next-state for pointers and status flags; clear_flags wins over set/increment.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (clear_flags) begin
      overflow_d = 1'b0;
      drop_cnt_d = {CNT_W{1'b0}};
    end else begin
      if (pixel_valid && full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      if (drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {(AW+1){1'b0}};
      rd_ptr_q   <= {(AW+1){1'b0}};
      overflow_q <= 1'b0;
      drop_cnt_q <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem_q[i] <= 32'h0000_0000;
        data_mem_q[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      addr_mem_q[wr_ptr_q[AW-1:0]] <= pix_addr_s;
      data_mem_q[wr_ptr_q[AW-1:0]] <= pixel_color;
    end else begin
      addr_mem_q[wr_ptr_q[AW-1:0]] <= addr_mem_q[wr_ptr_q[AW-1:0]];
      data_mem_q[wr_ptr_q[AW-1:0]] <= data_mem_q[wr_ptr_q[AW-1:0]];
    end
  end

  assign pixel_ready  = !full_s;
  assign mem_wr_valid = !empty_s;
  assign mem_wr_addr  = addr_mem_q[rd_ptr_q[AW-1:0]];
  assign mem_wr_data  = data_mem_q[rd_ptr_q[AW-1:0]];
  assign overflow     = overflow_q;
  assign drop_count   = drop_cnt_q;
  assign idle         = empty_s && !pixel_valid;

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: stimulus queues expected writes, a monitor
// pops and compares on every accepted memory request.
module tb_pixel_writer;

  localparam int DEPTH = 16;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   fb_base = 32'h0, fb_width = 32'h0, fb_height = 32'h0;
  logic          pixel_valid = 1'b0;
  logic [31:0]   pixel_x = 32'h0, pixel_y = 32'h0, pixel_color = 32'h0;
  logic          pixel_ready;
  logic          mem_wr_valid;
  logic          mem_wr_ready = 1'b0;
  logic [31:0]   mem_wr_addr, mem_wr_data;
  logic          clear_flags = 1'b0;
  logic          overflow;
  logic [CW-1:0] drop_count;
  logic          idle;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb[$];

  pixel_writer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fb_base(fb_base), .fb_width(fb_width),
    .fb_height(fb_height), .pixel_valid(pixel_valid), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pixel_color(pixel_color), .pixel_ready(pixel_ready),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .clear_flags(clear_flags), .overflow(overflow), .drop_count(drop_count),
    .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs change just after posedge, so negedge sees the handshake
  // that the next posedge will complete.
  logic        stalled = 1'b0;
  logic [63:0] held    = 64'h0;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else if (mem_wr_valid && mem_wr_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", mem_wr_addr, mem_wr_data);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("wr_addr", {32'h0, mem_wr_addr}, {32'h0, e[63:32]});
        chk("wr_data", {32'h0, mem_wr_data}, {32'h0, e[31:0]});
      end
      stalled = 1'b0;
    end else if (mem_wr_valid) begin
      if (stalled) chk("stall_hold", {mem_wr_addr, mem_wr_data}, held);
      held    = {mem_wr_addr, mem_wr_data};
      stalled = 1'b1;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c,
                      input bit exp_push, input logic [31:0] exp_addr);
    pixel_valid = 1'b1;
    pixel_x     = x;
    pixel_y     = y;
    pixel_color = c;
    if (exp_push) sb.push_back({exp_addr, c});
    @(posedge clk); #1;
    pixel_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
    chk("drain_valid", {63'h0, mem_wr_valid}, 64'd0);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {63'h0, mem_wr_valid}, 64'd0);
    chk("rst_ready", {63'h0, pixel_ready}, 64'd1);
    chk("rst_addr",  {32'h0, mem_wr_addr}, 64'd0);
    chk("rst_data",  {32'h0, mem_wr_data}, 64'd0);
    chk("rst_ovf",   {63'h0, overflow}, 64'd0);
    chk("rst_drop",  64'(drop_count), 64'd0);
    chk("rst_idle",  {63'h0, idle}, 64'd1);
    rst = 1'b0;

    // Clear stream 4x3
    fb_base = 32'h1000; fb_width = 32'd4; fb_height = 32'd3;
    mem_wr_ready = 1'b1;
    for (int i = 0; i < 12; i++)
      send(32'(i % 4), 32'(i / 4), 32'hA5A5A5A5, 1'b1, 32'h1000 + 32'(4 * i));
    wait_drain();
    chk("clr_idle", {63'h0, idle}, 64'd1);
    chk("clr_drop", 64'(drop_count), 64'd0);

    // Clipping
    pixel_valid = 1'b1; pixel_x = 32'd4; pixel_y = 32'd0; #1;
    chk("idle_busy", {63'h0, idle}, 64'd0);
    pixel_valid = 1'b0;
    send(32'd4, 32'd0, 32'h11111111, 1'b0, 32'h0);
    send(32'd0, 32'd3, 32'h22222222, 1'b0, 32'h0);
    send(32'hFFFFFFFF, 32'd1, 32'h33333333, 1'b0, 32'h0);
    send(32'd2, 32'd1, 32'h44444444, 1'b1, 32'h1018);
    wait_drain();
    chk("clip_drop", 64'(drop_count), 64'd3);

    // clear_flags beats a same-cycle drop
    clear_flags = 1'b1;
    send(32'd9, 32'd9, 32'h0, 1'b0, 32'h0);
    clear_flags = 1'b0;
    chk("clr_vs_drop", 64'(drop_count), 64'd0);

    // Saturation at all-ones
    for (int i = 0; i < 20; i++) send(32'd100, 32'd0, 32'h0, 1'b0, 32'h0);
    chk("drop_sat", 64'(drop_count), 64'd15);
    pulse_clear();

    // Zero-size framebuffer drops everything
    fb_width = 32'd0;
    send(32'd0, 32'd0, 32'h55555555, 1'b0, 32'h0);
    chk("zero_w_drop", 64'(drop_count), 64'd1);
    fb_width = 32'd4; fb_height = 32'd0;
    send(32'd0, 32'd0, 32'h55555555, 1'b0, 32'h0);
    chk("zero_h_drop", 64'(drop_count), 64'd2);
    pulse_clear();
    chk("zero_cleared", 64'(drop_count), 64'd0);

    // Backpressure: fill 16, 17th overflows
    fb_height = 32'd8;
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(32'(i % 4), 32'(i / 4), 32'hB000_0000 + 32'(i), 1'b1, 32'h1000 + 32'(4 * i));
      if (i == 0)  chk("latency_valid", {63'h0, mem_wr_valid}, 64'd1);
      if (i == 14) chk("bp_ready_15", {63'h0, pixel_ready}, 64'd1);
    end
    chk("bp_ready_16", {63'h0, pixel_ready}, 64'd0);
    send(32'd0, 32'd4, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("bp_ovf", {63'h0, overflow}, 64'd1);
    chk("bp_nodrop", 64'(drop_count), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    mem_wr_ready = 1'b1;
    wait_drain();
    chk("ovf_sticky", {63'h0, overflow}, 64'd1);
    pulse_clear();
    chk("ovf_clear", {63'h0, overflow}, 64'd0);

    // Push+pop at count 8 keeps the count at 8
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(32'(i % 4), 32'(i / 4), 32'hC000_0000 + 32'(i), 1'b1, 32'h1000 + 32'(4 * i));
    mem_wr_ready = 1'b1;
    for (int i = 8; i < 16; i++) begin
      send(32'(i % 4), 32'(i / 4), 32'hC000_0000 + 32'(i), 1'b1, 32'h1000 + 32'(4 * i));
      chk("pp_ready", {63'h0, pixel_ready}, 64'd1);
    end
    mem_wr_ready = 1'b0;
    for (int i = 16; i < 24; i++) begin
      send(32'(i % 4), 32'(i / 4), 32'hC000_0000 + 32'(i), 1'b1, 32'h1000 + 32'(4 * i));
      if (i == 22) chk("pp_ready_15", {63'h0, pixel_ready}, 64'd1);
    end
    chk("pp_full", {63'h0, pixel_ready}, 64'd0);
    mem_wr_ready = 1'b1;
    wait_drain();

    // Reset mid-burst with 5 buffered
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(32'(i), 32'd0, 32'hD000_0000 + 32'(i), 1'b1, 32'h1000 + 32'(4 * i));
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {63'h0, mem_wr_valid}, 64'd0);
    chk("mid_rst_ready", {63'h0, pixel_ready}, 64'd1);
    chk("mid_rst_ovf",   {63'h0, overflow}, 64'd0);
    mem_wr_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_quiet", {63'h0, mem_wr_valid}, 64'd0);

    // Address wrap modulo 2^32
    fb_base = 32'hFFFFFFF8; fb_width = 32'd4; fb_height = 32'd3;
    mem_wr_ready = 1'b0;
    send(32'd3, 32'd0, 32'h77777777, 1'b1, 32'h00000004);
    chk("wrap_valid", {63'h0, mem_wr_valid}, 64'd1);
    chk("wrap_addr", {32'h0, mem_wr_addr}, 64'h4);
    mem_wr_ready = 1'b1;
    wait_drain();
    chk("final_idle", {63'h0, idle}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
